// File: rtl/track_scroller_if.sv
// rtl/track_scroller_if.sv - control inputs and map/status outputs of the track scroller
interface track_scroller_if #(
    parameter int NSEG = 16
);
    logic            start;
    logic            flip_btn;
    logic [8:0]      height;
    logic [2:0]      lines;
    logic            grav_dir;
    logic            is_dead;
    logic [NSEG-1:0] map_top;
    logic [NSEG-1:0] map_mid;
    logic [NSEG-1:0] map_bot;
    logic [5:0]      pix_off;
    logic [15:0]     score;

    modport master (
        output start, flip_btn, height,
        input  lines, grav_dir, is_dead, map_top, map_mid, map_bot, pix_off, score
    );

    modport slave (
        input  start, flip_btn, height,
        output lines, grav_dir, is_dead, map_top, map_mid, map_bot, pix_off, score
    );
endinterface

// File: rtl/track_scroller.sv
// rtl/track_scroller.sv - scrolling three-line track map, gravity flip and death detection
module track_scroller #(
    parameter int          SEG_W      = 40,
    parameter int          NSEG       = 16,
    parameter int          SCROLL_DIV = 4,
    parameter int          PLAYER_SEG = 2,
    parameter int          SAFE_SEGS  = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    track_scroller_if.slave   bus
);
    localparam int DIV_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int SAFE_W = $clog2(SAFE_SEGS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        pix_q, pix_d;
    logic [NSEG-1:0]   top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic              grav_q, grav_d;
    logic              dead_q, dead_d;
    logic [15:0]       score_q, score_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [SAFE_W-1:0] safe_q, safe_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;

    logic [2:0] lines_w;
    logic [2:0] new_col;
    logic       lfsr_fb;
    logic       flip_rise;
    logic       grounded;
    logic       die_cond;

    assign lines_w   = {bot_q[PLAYER_SEG], mid_q[PLAYER_SEG], top_q[PLAYER_SEG]};
    assign flip_rise = sync2_q & ~edge_q;
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign die_cond  = (bus.height == 9'd0) || (bus.height >= 9'd420);

    // A column with no line at all would be unwinnable, so 000 becomes middle-only.
    assign new_col = (safe_q != '0)          ? 3'b010 :
                     (lfsr_q[2:0] == 3'b000) ? 3'b010 : lfsr_q[2:0];

    assign grounded = (~grav_q & (((bus.height == 9'd180) & lines_w[1]) |
                                  ((bus.height == 9'd300) & lines_w[2]))) |
                      ( grav_q & (((bus.height == 9'd120) & lines_w[0]) |
                                  ((bus.height == 9'd240) & lines_w[1])));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            pix_q   <= '0;
            top_q   <= '0;
            mid_q   <= '1;
            bot_q   <= '0;
            grav_q  <= 1'b0;
            dead_q  <= 1'b0;
            score_q <= '0;
            lfsr_q  <= LFSR_SEED;
            safe_q  <= SAFE_W'(SAFE_SEGS);
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pix_q   <= pix_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            grav_q  <= grav_d;
            dead_q  <= dead_d;
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
            safe_q  <= safe_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pix_d   = pix_q;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        grav_d  = grav_q;
        dead_d  = dead_q;
        score_d = score_q;
        lfsr_d  = lfsr_q;
        safe_d  = safe_q;
        sync1_d = bus.flip_btn;
        sync2_d = sync1_q;
        edge_d  = sync2_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
                // Death freezes everything in the same cycle, including a pending shift or flip.
                if (die_cond) begin
                    state_d = S_DEAD;
                    dead_d  = 1'b1;
                end else begin
                    if (flip_rise && grounded) grav_d = ~grav_q;
                    if (div_q == DIV_W'(SCROLL_DIV - 1)) begin
                        div_d = '0;
                        if (pix_q == 6'(SEG_W - 1)) begin
                            pix_d  = '0;
                            top_d  = {new_col[0], top_q[NSEG-1:1]};
                            mid_d  = {new_col[1], mid_q[NSEG-1:1]};
                            bot_d  = {new_col[2], bot_q[NSEG-1:1]};
                            lfsr_d = {lfsr_q[14:0], lfsr_fb};
                            if (safe_q != '0) safe_d = safe_q - SAFE_W'(1);
                            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                        end else begin
                            pix_d = pix_q + 6'd1;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            S_DEAD: begin
                // Restart reinitialises the level but keeps the LFSR so each run differs.
                if (bus.start) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    pix_d   = '0;
                    top_d   = '0;
                    mid_d   = '1;
                    bot_d   = '0;
                    grav_d  = 1'b0;
                    dead_d  = 1'b0;
                    score_d = '0;
                    safe_d  = SAFE_W'(SAFE_SEGS);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.lines    = lines_w;
    assign bus.grav_dir = grav_q;
    assign bus.is_dead  = dead_q;
    assign bus.map_top  = top_q;
    assign bus.map_mid  = mid_q;
    assign bus.map_bot  = bot_q;
    assign bus.pix_off  = pix_q;
    assign bus.score    = score_q;
endmodule

// File: tb/tb_track_scroller.sv
// tb/tb_track_scroller.sv - randomized bench with a column-queue reference model of the track scroller
module tb_track_scroller;
    localparam int NSEG = 16;
    localparam int PSEG = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    track_scroller_if #(.NSEG(NSEG)) bus();
    track_scroller dut (.clk(clk), .reset(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: live RUN cycle count plus a column array per map position.
    int          m_state;
    int          m_t;
    logic [2:0]  m_cols [NSEG];
    logic [15:0] m_lfsr;
    int          m_safe;
    logic        m_grav;
    logic [2:0]  m_h;

    logic [NSEG-1:0] m_top, m_mid, m_bot;
    logic [2:0]      m_lines, m_newcol;
    logic [15:0]     m_next_lfsr;
    int              m_pix, m_score;
    logic            m_die, m_rise, m_ground, m_shift;

    always_comb begin
        m_top = '0;
        m_mid = '0;
        m_bot = '0;
        for (int i = 0; i < NSEG; i++) begin
            m_top[i] = m_cols[i][0];
            m_mid[i] = m_cols[i][1];
            m_bot[i] = m_cols[i][2];
        end
        m_lines     = m_cols[PSEG];
        m_pix       = (m_t / 4) % 40;
        m_score     = (m_t / 160 > 65535) ? 65535 : m_t / 160;
        m_die       = (bus.height == 0) || (bus.height >= 420);
        m_rise      = m_h[1] & ~m_h[2];
        m_ground    = m_grav ? ((bus.height == 120 && m_lines[0]) || (bus.height == 240 && m_lines[1]))
                             : ((bus.height == 180 && m_lines[1]) || (bus.height == 300 && m_lines[2]));
        m_newcol    = (m_safe > 0 || m_lfsr[2:0] == 3'b000) ? 3'b010 : m_lfsr[2:0];
        m_next_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        m_shift     = ((m_t + 1) % 160) == 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_t     <= 0;
            for (int i = 0; i < NSEG; i++) m_cols[i] <= 3'b010;
            m_lfsr  <= 16'hACE1;
            m_safe  <= 4;
            m_grav  <= 1'b0;
            m_h     <= 3'b000;
        end else begin
            m_h <= {m_h[1:0], bus.flip_btn};
            case (m_state)
                0: if (bus.start) m_state <= 1;
                1: begin
                    if (m_die) begin
                        m_state <= 2;
                    end else begin
                        if (m_rise && m_ground) m_grav <= ~m_grav;
                        m_t <= m_t + 1;
                        if (m_shift) begin
                            for (int i = 0; i < NSEG - 1; i++) m_cols[i] <= m_cols[i+1];
                            m_cols[NSEG-1] <= m_newcol;
                            m_lfsr <= m_next_lfsr;
                            if (m_safe > 0) m_safe <= m_safe - 1;
                        end
                    end
                end
                default: begin
                    if (bus.start) begin
                        m_state <= 0;
                        m_t     <= 0;
                        for (int i = 0; i < NSEG; i++) m_cols[i] <= 3'b010;
                        m_safe  <= 4;
                        m_grav  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("lines",    {29'd0, bus.lines},    {29'd0, m_lines});
            check("grav_dir", {31'd0, bus.grav_dir}, {31'd0, m_grav});
            check("is_dead",  {31'd0, bus.is_dead},  {31'd0, (m_state == 2)});
            check("map_top",  {16'd0, bus.map_top},  {16'd0, m_top});
            check("map_mid",  {16'd0, bus.map_mid},  {16'd0, m_mid});
            check("map_bot",  {16'd0, bus.map_bot},  {16'd0, m_bot});
            check("pix_off",  {26'd0, bus.pix_off},  m_pix);
            check("score",    {16'd0, bus.score},    m_score);
            check("col_nonzero", {16'd0, bus.map_top | bus.map_mid | bus.map_bot}, 32'h0000FFFF);
        end
    end

    int hts [6] = '{120, 180, 200, 240, 300, 360};
    logic [15:0] sc_hold;
    logic [5:0]  px_hold;
    int cnt;

    task automatic flip_pulse();
        @(negedge clk) bus.flip_btn = 1'b1;
        repeat (4) @(negedge clk);
        bus.flip_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.flip_btn = 1'b0;
        bus.height   = 9'd180;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_score", {16'd0, bus.score}, 0);
        check("rst_mid",   {16'd0, bus.map_mid}, 32'h0000FFFF);
        check("rst_top",   {16'd0, bus.map_top}, 0);
        check("rst_dead",  {31'd0, bus.is_dead}, 0);
        check("rst_pix",   {26'd0, bus.pix_off}, 0);
        rst_n = 1'b1;

        // Start, then the first shift lands exactly 160 clocks after RUN entry.
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.start = 1'b0;
        check("start_lines", {29'd0, bus.lines}, 32'd2);
        check("start_alive", {31'd0, bus.is_dead}, 0);
        repeat (159) @(posedge clk);
        #1;
        check("pre_shift_pix",   {26'd0, bus.pix_off}, 39);
        check("pre_shift_score", {16'd0, bus.score}, 0);
        @(posedge clk);
        #1;
        check("shift1_score", {16'd0, bus.score}, 1);
        check("shift1_pix",   {26'd0, bus.pix_off}, 0);

        @(negedge clk) bus.height = 9'd200;
        flip_pulse();
        check("flip_airborne", {31'd0, bus.grav_dir}, 0);
        @(negedge clk) bus.height = 9'd180;
        flip_pulse();
        check("flip_ground", {31'd0, bus.grav_dir}, 1);
        @(negedge clk) bus.height = 9'd240;
        flip_pulse();
        check("flip_back", {31'd0, bus.grav_dir}, 0);
        bus.height = 9'd180;

        cnt = 0;
        while (bus.score < 16'd4 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_4", {16'd0, bus.score}, 4);
        check("safe_top", {16'd0, bus.map_top}, 0);
        check("safe_bot", {16'd0, bus.map_bot}, 0);
        check("safe_mid", {16'd0, bus.map_mid}, 32'h0000FFFF);

        repeat (5000) begin
            @(negedge clk);
            bus.height = 9'(hts[$urandom_range(0, 5)]);
            if ($urandom_range(0, 15) == 0) bus.flip_btn = ~bus.flip_btn;
            bus.start = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk) begin
            bus.start    = 1'b0;
            bus.flip_btn = 1'b0;
        end
        check("random_progress", {31'd0, (bus.score >= 16'd30)}, 1);

        @(negedge clk) bus.height = 9'd420;
        @(posedge clk);
        #1;
        check("dead_420", {31'd0, bus.is_dead}, 1);
        sc_hold = bus.score;
        px_hold = bus.pix_off;
        bus.flip_btn = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("frozen_score", {16'd0, bus.score}, {16'd0, sc_hold});
        check("frozen_pix",   {26'd0, bus.pix_off}, {26'd0, px_hold});

        @(negedge clk) begin
            bus.flip_btn = 1'b0;
            bus.height   = 9'd180;
            bus.start    = 1'b1;
        end
        @(posedge clk);
        #1;
        check("restart_score", {16'd0, bus.score}, 0);
        check("restart_mid",   {16'd0, bus.map_mid}, 32'h0000FFFF);
        check("restart_grav",  {31'd0, bus.grav_dir}, 0);
        check("restart_alive", {31'd0, bus.is_dead}, 0);
        @(negedge clk) bus.start = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (50) @(negedge clk);
        bus.height = 9'd0;
        @(posedge clk);
        #1;
        check("dead_0", {31'd0, bus.is_dead}, 1);
        sc_hold = bus.score;
        repeat (200) @(posedge clk);
        #1;
        check("frozen_score_0", {16'd0, bus.score}, {16'd0, sc_hold});

        @(negedge clk) begin
            bus.height = 9'd180;
            bus.start  = 1'b1;
        end
        @(negedge clk) bus.start = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (300) @(negedge clk);
        check("midrun_score", {16'd0, bus.score}, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_score", {16'd0, bus.score}, 0);
        check("async_rst_pix",   {26'd0, bus.pix_off}, 0);
        check("async_rst_mid",   {16'd0, bus.map_mid}, 32'h0000FFFF);
        check("async_rst_top",   {16'd0, bus.map_top}, 0);
        check("async_rst_dead",  {31'd0, bus.is_dead}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
